// File: rtl/rf_bypass_8x16_if.sv
// Register-file access bundle: two read ports, one write port, error flag.
// The master drives selects/write data; the slave returns read data.
interface rf_bypass_8x16_if;
  logic [2:0]  read1RegSel;
  logic [2:0]  read2RegSel;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic        err;

  modport master (
    output read1RegSel,
    output read2RegSel,
    output writeRegSel,
    output writeData,
    output writeEn,
    input  read1Data,
    input  read2Data,
    input  err
  );

  modport slave (
    input  read1RegSel,
    input  read2RegSel,
    input  writeRegSel,
    input  writeData,
    input  writeEn,
    output read1Data,
    output read2Data,
    output err
  );
endinterface

// File: rtl/rf_bypass_8x16.sv
// Eight-entry 16-bit register file: two combinational read ports,
// one synchronous write port, optional same-cycle write-to-read bypass.
module rf_reg16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end
endmodule

module mux_8by16bit (
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic [15:0] in7,
  input  logic [2:0]  sel,
  output logic [15:0] out
);
  always_comb begin
    out = in0;
    unique case (sel)
      3'd0: out = in0;
      3'd1: out = in1;
      3'd2: out = in2;
      3'd3: out = in3;
      3'd4: out = in4;
      3'd5: out = in5;
      3'd6: out = in6;
      3'd7: out = in7;
      default: out = in0;
    endcase
  end
endmodule

module rf_bypass_8x16 #(
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  rf_bypass_8x16_if.slave rf
);
  logic [15:0] regs [8];
  logic [7:0]  wr_dec;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic        wr_live;
  logic        hit1;
  logic        hit2;

  always_comb begin
    wr_dec = '0;
    wr_dec[rf.writeRegSel] = rf.writeEn;
  end

  for (genvar i = 0; i < 8; i++) begin : g_reg
    rf_reg16 u_reg (
      .clk (clk),
      .rst (rst),
      .en  (wr_dec[i]),
      .d   (rf.writeData),
      .q   (regs[i])
    );
  end

  mux_8by16bit u_rd1 (
    .in0 (regs[0]),
    .in1 (regs[1]),
    .in2 (regs[2]),
    .in3 (regs[3]),
    .in4 (regs[4]),
    .in5 (regs[5]),
    .in6 (regs[6]),
    .in7 (regs[7]),
    .sel (rf.read1RegSel),
    .out (rd1)
  );

  mux_8by16bit u_rd2 (
    .in0 (regs[0]),
    .in1 (regs[1]),
    .in2 (regs[2]),
    .in3 (regs[3]),
    .in4 (regs[4]),
    .in5 (regs[5]),
    .in6 (regs[6]),
    .in7 (regs[7]),
    .sel (rf.read2RegSel),
    .out (rd2)
  );

  // A write that reset is discarding must not be forwarded either.
  assign wr_live = rf.writeEn & ~rst;

  assign hit1 = BYPASS & wr_live &
                (rf.writeRegSel == rf.read1RegSel);
  assign hit2 = BYPASS & wr_live &
                (rf.writeRegSel == rf.read2RegSel);

  assign rf.read1Data = hit1 ? rf.writeData : rd1;
  assign rf.read2Data = hit2 ? rf.writeData : rd2;
  assign rf.err       = rst & rf.writeEn;
endmodule

// File: tb/tb_rf_bypass_8x16.sv
// Directed vector bench: one bypassing and one non-bypassing instance
// driven in lockstep, checked against hand-computed expectations.
module tb_rf_bypass_8x16;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rf_bypass_8x16_if if_b ();
  rf_bypass_8x16_if if_n ();

  rf_bypass_8x16 #(.BYPASS(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .rf  (if_b.slave)
  );

  rf_bypass_8x16 #(.BYPASS(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .rf  (if_n.slave)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [15:0] n1;
    logic [15:0] n2;
    logic        err;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;
  int   total = 0;
  int   bad = 0;

  task automatic add(
    input logic rs, input logic we,
    input logic [2:0] ws, input logic [15:0] wd,
    input logic [2:0] r1, input logic [2:0] r2,
    input logic [15:0] b1, input logic [15:0] b2,
    input logic [15:0] n1, input logic [15:0] n2,
    input logic er);
    vecs[nvec] = '{rs, we, ws, wd, r1, r2, b1, b2, n1, n2, er};
    nvec++;
  endtask

  task automatic drive(
    input logic rs, input logic we,
    input logic [2:0] ws, input logic [15:0] wd,
    input logic [2:0] r1, input logic [2:0] r2);
    rst = rs;
    if_b.writeEn = we;     if_n.writeEn = we;
    if_b.writeRegSel = ws; if_n.writeRegSel = ws;
    if_b.writeData = wd;   if_n.writeData = wd;
    if_b.read1RegSel = r1; if_n.read1RegSel = r1;
    if_b.read2RegSel = r2; if_n.read2RegSel = r2;
  endtask

  task automatic check(
    input string name, input int row,
    input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h",
               name, row, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 16'h0, 3'(i), 3'(7 - i),
          0, 0, 0, 0, 0);
    add(0, 1, 3, 16'hBEEF, 3, 7,
        16'hBEEF, 0, 0, 0, 0);
    add(0, 1, 7, 16'h1234, 3, 7,
        16'hBEEF, 16'h1234, 16'hBEEF, 0, 0);
    add(0, 0, 0, 16'h0, 3, 7,
        16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234, 0);
    add(0, 0, 0, 16'h0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0, 2, 4, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0, 5, 6, 0, 0, 0, 0, 0);
    add(0, 1, 5, 16'h00AA, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 16'h5555, 5, 5,
        16'h5555, 16'h5555, 16'h00AA, 16'h00AA, 0);
    add(0, 0, 0, 16'h0, 5, 5,
        16'h5555, 16'h5555, 16'h5555, 16'h5555, 0);
    add(0, 1, 2, 16'hFFFF, 2, 3,
        16'hFFFF, 16'hBEEF, 0, 16'hBEEF, 0);
    add(1, 1, 2, 16'h7777, 2, 2,
        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1);
    add(0, 0, 0, 16'h0, 2, 3, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0, 5, 7, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0001, 0, 1, 16'h0001, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0002, 0, 0,
        16'h0002, 16'h0002, 16'h0001, 16'h0001, 0);
    add(0, 0, 0, 16'h0, 0, 0,
        16'h0002, 16'h0002, 16'h0002, 16'h0002, 0);
    add(0, 1, 1, 16'hA5A5, 1, 6, 16'hA5A5, 0, 0, 0, 0);
    add(0, 1, 6, 16'h5A5A, 6, 1,
        16'h5A5A, 16'hA5A5, 0, 16'hA5A5, 0);
    add(0, 1, 4, 16'hC3C3, 6, 1,
        16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5, 0);
    add(0, 0, 0, 16'h0, 4, 0,
        16'hC3C3, 16'h0002, 16'hC3C3, 16'h0002, 0);
    add(1, 0, 0, 16'h0, 4, 1,
        16'hC3C3, 16'hA5A5, 16'hC3C3, 16'hA5A5, 0);
    add(0, 1, 3, 16'h1111, 4, 3, 0, 16'h1111, 0, 0, 0);
    add(0, 0, 0, 16'h0, 3, 3,
        16'h1111, 16'h1111, 16'h1111, 16'h1111, 0);

    // Initial reset: storage is unknown before it, so only err is checked.
    drive(1, 0, 0, 16'h0, 0, 0);
    @(negedge clk);
    #1;
    check("rst_err_b", -1, 16'(if_b.err), 16'h0);
    check("rst_err_n", -1, 16'(if_n.err), 16'h0);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wsel,
            vecs[i].wdata, vecs[i].r1, vecs[i].r2);
      #1;
      check("b_rd1", i, if_b.read1Data, vecs[i].b1);
      check("b_rd2", i, if_b.read2Data, vecs[i].b2);
      check("n_rd1", i, if_n.read1Data, vecs[i].n1);
      check("n_rd2", i, if_n.read2Data, vecs[i].n2);
      check("b_err", i, 16'(if_b.err), 16'(vecs[i].err));
      check("n_err", i, 16'(if_n.err), 16'(vecs[i].err));
      @(posedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
